mac_share_arb: RTL
==================

Name: mac_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one fixed-latency multiply-add unit (DSP48E2 configured as A*B+C, P = A*B + C) among NREQ requesters.
- Accepts at most one operation per cycle over valid/ready handshakes and drives the unit's operand inputs.
- Tracks each in-flight operation with a requester tag through a LAT-deep pipeline.
- Returns each result to the owning requester as a one-cycle valid pulse.

Parameters:
- NREQ, 4, number of requesters (1..16).
- LAT, 3, cycles from operands presented on mac_a/mac_b/mac_c to the matching value on mac_p (AREG/BREG + MREG + PREG).
- AW, 18, width of A and B operands (signed two's complement).
- CW, 48, width of C operand and P result.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operation valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*AW  A operands, requester i at bits [i*AW +: AW].
- req_b  in  NREQ*AW  B operands, same packing as req_a.
- req_c  in  NREQ*CW  C operands, requester i at bits [i*CW +: CW].
- mac_a  out  AW  operand A to the shared unit.
- mac_b  out  AW  operand B to the shared unit.
- mac_c  out  CW  operand C to the shared unit.
- mac_vld  out  1  operands on mac_a/mac_b/mac_c are a real issue.
- mac_p  in  CW  result from the shared unit.
- rsp_valid  out  NREQ  one-cycle result pulse, one-hot or zero.
- rsp_p  out  CW  result data, qualified by rsp_valid.

Behaviour:
- Reset (synchronous, active-high on RST):
  - Round-robin pointer ptr = 0.
  - mac_a = mac_b = mac_c = 0 and mac_vld = 0.
  - rsp_valid = 0 and rsp_p = 0.
  - Tag/valid pipeline cleared, so in-flight operations are dropped and never respond.
  - req_ready = 0 while RST is high.
- Arbitration (combinational):
  - Grant g is the first i with req_valid[i]=1, scanning ptr, ptr+1, ..., wrapping NREQ-1 -> 0.
  - req_ready[g]=1; all other req_ready bits are 0. With no valid requester, req_ready=0.
  - req_ready may depend on req_valid in the same cycle.
  - Handshake occurs in cycle t when req_valid[g] & req_ready[g].
  - A requester must hold req_valid and its operands stable until granted; it may not withdraw.
- Pointer update: on a handshake, ptr <= (g+1) mod NREQ. With no handshake, ptr holds.
- Issue (registered):
  - Handshake in cycle t: mac_a/mac_b/mac_c <= requester g's operands, mac_vld <= 1, visible in cycle t+1.
  - No handshake: mac_a/mac_b/mac_c <= 0 and mac_vld <= 0.
  - Throughput is one operation per cycle, with no bubbles between back-to-back grants.
- Tracking:
  - A shift register of depth LAT carries {vld, tag} alongside the issue.
  - The pipeline entry entering in cycle t+1 exits in cycle t+1+LAT, aligned with mac_p for that operation.
- Response (registered): when the exiting entry is valid, rsp_valid[tag] <= 1 and rsp_p <= mac_p; otherwise rsp_valid <= 0 and rsp_p holds.
- Latency: handshake cycle t -> rsp_valid in cycle t+LAT+2 (5 cycles at LAT=3).
- Ordering: responses return in issue order and are never backpressured; requesters must always sink them.
- Arithmetic: performed entirely by the external unit; the block passes operands unmodified and does no width conversion.
- Boundaries:
  - NREQ=1: requester 0 is always granted when valid; ptr stays 0.
  - ptr wraps from NREQ-1 to 0.
  - A requester may issue every cycle when it is the only one valid.
  - RST asserted with operations in flight: no rsp_valid for any of them after reset.

Optional Feature:
- MAC_ARB_STATS_EN defined adds two outputs:
  - stat_issued (32): counts handshakes.
  - stat_contend (32): counts cycles with two or more req_valid bits set.
  - Both reset to 0, increment by 1, and wrap at 2^32.
- MAC_ARB_STATS_EN undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Only requester 0 valid in cycle 2 with A=2, B=3, C=1 -> req_ready[0]=1 in cycle 2; rsp_valid[0]=1 with rsp_p=7 in cycle 7 (LAT=3); ptr=1 afterwards.
- All 4 requesters valid from reset with A=i+1, B=10, C=0 -> grants 0,1,2,3 on consecutive cycles; rsp_p = 10,20,30,40 on consecutive cycles with the matching one-hot rsp_valid.
- ptr=2 after a grant to requester 1, then requesters 1 and 3 valid -> requester 3 granted first, then requester 1 on the next cycle.
- Requester 2 alone streams 8 operations (A=100, B=10, C=5) -> 8 consecutive req_ready cycles; 8 consecutive rsp_valid[2] pulses with rsp_p=1005 each.
- Signed operation A=-2, B=3, C=10 -> rsp_p=4. Separately, RST pulsed 2 cycles after issuing 3 operations -> no rsp_valid ever; mac_vld=0 and ptr=0 after reset.
- With MAC_ARB_STATS_EN: the 4-requester scenario -> stat_issued=4, stat_contend=3.

Source files
------------

// File: rtl/mac_share_arb.sv
// Round-robin arbiter/sequencer sharing one fixed-latency A*B+C unit among NREQ requesters.
// Define MAC_ARB_STATS_EN to add the stat_issued / stat_contend counters.
module mac_share_arb #(
   parameter int NREQ = 4,
   parameter int LAT  = 3,
   parameter int AW   = 18,
   parameter int CW   = 48
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*AW-1:0]   req_a,
   input  logic [NREQ*AW-1:0]   req_b,
   input  logic [NREQ*CW-1:0]   req_c,
   output logic [AW-1:0]        mac_a,
   output logic [AW-1:0]        mac_b,
   output logic [CW-1:0]        mac_c,
   output logic                 mac_vld,
   input  logic [CW-1:0]        mac_p,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [CW-1:0]        rsp_p
`ifdef MAC_ARB_STATS_EN
   ,
   output logic [31:0]          stat_issued,
   output logic [31:0]          stat_contend
`endif
);
   localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [TW-1:0]        ptr, g, g_hi, g_lo;
   logic                 f_hi, f_lo, hs;
   logic [AW-1:0]        a_arr [NREQ];
   logic [AW-1:0]        b_arr [NREQ];
   logic [CW-1:0]        c_arr [NREQ];
   logic [LAT:0]         vld_pipe;
   logic [LAT:0][TW-1:0] tag_pipe;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         a_arr[i] = req_a[i*AW +: AW];
         b_arr[i] = req_b[i*AW +: AW];
         c_arr[i] = req_c[i*CW +: CW];
      end
   end

   // Lowest valid index at or above ptr wins; otherwise wrap to the lowest valid index.
   always_comb begin
      f_hi = 1'b0;
      f_lo = 1'b0;
      g_hi = '0;
      g_lo = '0;
      for (int i = NREQ-1; i >= 0; i--) begin
         if (req_valid[i]) begin
            f_lo = 1'b1;
            g_lo = TW'(i);
            if (TW'(i) >= ptr) begin
               f_hi = 1'b1;
               g_hi = TW'(i);
            end
         end
      end
      g = f_hi ? g_hi : g_lo;
   end

   assign hs        = f_lo & ~RST;
   assign req_ready = hs ? (NREQ'(1) << g) : '0;

   // vld_pipe[0] lines up with mac_vld; vld_pipe[LAT] lines up with mac_p.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr       <= '0;
         mac_a     <= '0;
         mac_b     <= '0;
         mac_c     <= '0;
         mac_vld   <= 1'b0;
         vld_pipe  <= '0;
         tag_pipe  <= '0;
         rsp_valid <= '0;
         rsp_p     <= '0;
      end else begin
         if (hs) ptr <= (g == TW'(NREQ-1)) ? '0 : g + 1'b1;
         mac_vld   <= hs;
         mac_a     <= hs ? a_arr[g] : '0;
         mac_b     <= hs ? b_arr[g] : '0;
         mac_c     <= hs ? c_arr[g] : '0;
         vld_pipe  <= {vld_pipe[LAT-1:0], hs};
         tag_pipe  <= {tag_pipe[LAT-1:0], g};
         rsp_valid <= vld_pipe[LAT] ? (NREQ'(1) << tag_pipe[LAT]) : '0;
         if (vld_pipe[LAT]) rsp_p <= mac_p;
      end
   end

`ifdef MAC_ARB_STATS_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         stat_issued  <= '0;
         stat_contend <= '0;
      end else begin
         if (hs) stat_issued <= stat_issued + 32'd1;
         if ($countones(req_valid) > 1) stat_contend <= stat_contend + 32'd1;
      end
   end
`endif

endmodule
